// File: rtl/scalar_alu_arbiter.sv
// Round-robin arbiter sharing one scalar ALU between the scalar pipeline (slot 0)
// and the vector address generator (slot 1); one operation in flight at a time.
module scalar_alu_arbiter #(
  parameter int SCALAR_REG_LEN = 64,
  parameter int DATA_LEN       = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [2*SCALAR_REG_LEN-1:0] req_rs1,
  input  logic [2*SCALAR_REG_LEN-1:0] req_rs2,
  input  logic [2*SCALAR_REG_LEN-1:0] req_imm,
  input  logic [2*DATA_LEN-1:0]       req_pc,
  input  logic [7:0]                  req_alu_signal,
  input  logic [7:0]                  req_func_code,
  output logic [SCALAR_REG_LEN-1:0]   alu_rs1,
  output logic [SCALAR_REG_LEN-1:0]   alu_rs2,
  output logic [SCALAR_REG_LEN-1:0]   alu_imm,
  output logic [DATA_LEN-1:0]         alu_pc,
  output logic [3:0]                  alu_signal,
  output logic [3:0]                  alu_func_code,
  input  logic [SCALAR_REG_LEN-1:0]   alu_result,
  input  logic [1:0]                  alu_sign_bits,
  output logic [1:0]                  resp_valid,
  input  logic [1:0]                  resp_ready,
  output logic [SCALAR_REG_LEN-1:0]   resp_result,
  output logic [1:0]                  resp_sign_bits,
  output logic                        busy
);

  localparam logic [3:0] ALU_NOP = 4'h0;
  localparam int W = SCALAR_REG_LEN;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  // Handshake: a request transfers on a rising edge where req_valid[i] & req_ready[i];
  // a response transfers on a rising edge where resp_valid[i] & resp_ready[i].
  state_t state, next_state;
  logic   owner;
  logic   last_grant;
  logic [1:0] grant;
  logic   grant_slot;

  always_comb begin
    grant = 2'b00;
    if (rst_n && state == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready  = grant;
  assign grant_slot = grant[1];

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant != 2'b00) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (resp_ready[owner]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      alu_rs1        <= '0;
      alu_rs2        <= '0;
      alu_imm        <= '0;
      alu_pc         <= '0;
      alu_signal     <= ALU_NOP;
      alu_func_code  <= '0;
      resp_result    <= '0;
      resp_sign_bits <= '0;
    end else begin
      if (grant != 2'b00) begin
        owner         <= grant_slot;
        last_grant    <= grant_slot;
        alu_rs1       <= grant_slot ? req_rs1[2*W-1:W] : req_rs1[W-1:0];
        alu_rs2       <= grant_slot ? req_rs2[2*W-1:W] : req_rs2[W-1:0];
        alu_imm       <= grant_slot ? req_imm[2*W-1:W] : req_imm[W-1:0];
        alu_pc        <= grant_slot ? req_pc[2*DATA_LEN-1:DATA_LEN] : req_pc[DATA_LEN-1:0];
        alu_signal    <= grant_slot ? req_alu_signal[7:4] : req_alu_signal[3:0];
        alu_func_code <= grant_slot ? req_func_code[7:4] : req_func_code[3:0];
      end
      // Operands stay put after EXEC; only the op class returns to NOP.
      if (state == EXEC) begin
        resp_result    <= alu_result;
        resp_sign_bits <= alu_sign_bits;
        alu_signal     <= ALU_NOP;
      end
    end
  end

  assign resp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_scalar_alu_arbiter.sv
// Bench for scalar_alu_arbiter: a behavioural ALU, vector table, corner sequences
// and a response scoreboard keyed on {slot, sign, result}.
module tb_scalar_alu_arbiter;

  localparam int W  = 64;
  localparam int DL = 32;
  localparam int EW = W + 3;
  localparam logic [3:0] NOP = 4'h0, SIG_BIN = 4'h1, SIG_PC = 4'h2;
  localparam logic [3:0] FN_ADD = 4'h0, FN_SUB = 4'h1;
  localparam logic [1:0] ZERO = 2'b00, POS = 2'b01, NEG = 2'b10;

  typedef struct {
    int          slot;
    logic [3:0]  sig;
    logic [3:0]  fn;
    logic [W-1:0]  rs1;
    logic [W-1:0]  rs2;
    logic [W-1:0]  imm;
    logic [DL-1:0] pc;
    logic [W-1:0]  exp_res;
    logic [1:0]    exp_sign;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [2*W-1:0] req_rs1 = '0, req_rs2 = '0, req_imm = '0;
  logic [2*DL-1:0] req_pc = '0;
  logic [7:0] req_alu_signal = '0, req_func_code = '0;
  logic [W-1:0] alu_rs1, alu_rs2, alu_imm, alu_result, resp_result;
  logic [DL-1:0] alu_pc;
  logic [3:0] alu_signal, alu_func_code;
  logic [1:0] alu_sign_bits, resp_sign_bits;
  logic busy;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  vec_t vecs[7];

  // clock / reset block
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  scalar_alu_arbiter #(.SCALAR_REG_LEN(W), .DATA_LEN(DL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_pc(req_pc),
    .req_alu_signal(req_alu_signal), .req_func_code(req_func_code),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_signal(alu_signal), .alu_func_code(alu_func_code),
    .alu_result(alu_result), .alu_sign_bits(alu_sign_bits),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_sign_bits(resp_sign_bits),
    .busy(busy)
  );

  // behavioural shared ALU
  always_comb begin
    alu_result = '0;
    case (alu_signal)
      SIG_BIN: alu_result = (alu_func_code == FN_SUB) ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;
      SIG_PC:  alu_result = {{(W-DL){1'b0}}, alu_pc} + alu_imm;
      default: alu_result = '0;
    endcase
    alu_sign_bits = (alu_result == '0) ? ZERO : (alu_result[W-1] ? NEG : POS);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: pop on every response handshake
  always begin
    logic [EW-1:0] e;
    @(negedge clk);
    #2;
    if (rst_n && (resp_valid & resp_ready) != 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=%b result=0x%0h, no response expected", resp_valid, resp_result);
      end else begin
        e = exp_q.pop_front();
        check("sb_slot", resp_valid, e[EW-1] ? 2'b10 : 2'b01);
        check("sb_sign", resp_sign_bits, e[W+1:W]);
        check("sb_result", resp_result, e[W-1:0]);
      end
    end
  end

  // driver tasks
  task automatic drive_slot(input vec_t v);
    int s;
    s = v.slot;
    req_rs1[s*W +: W] = v.rs1;
    req_rs2[s*W +: W] = v.rs2;
    req_imm[s*W +: W] = v.imm;
    req_pc[s*DL +: DL] = v.pc;
    req_alu_signal[s*4 +: 4] = v.sig;
    req_func_code[s*4 +: 4] = v.fn;
  endtask

  task automatic wait_ready(input logic [1:0] oh, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready == oh) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("accept_timeout", ok, 1);
  endtask

  task automatic push_exp(input int slot, input logic [1:0] sign, input logic [W-1:0] res);
    exp_q.push_back({slot[0], sign, res});
  endtask

  task automatic run_single(input vec_t v);
    logic [1:0] oh;
    bit ok;
    oh = (v.slot == 1) ? 2'b10 : 2'b01;
    drive_slot(v);
    req_valid = oh;
    resp_ready = 2'b11;
    #1;
    wait_ready(oh, ok);
    push_exp(v.slot, v.exp_sign, v.exp_res);
    @(negedge clk);
    req_valid = 2'b00;
    check("exec_signal", alu_signal, v.sig);
    check("exec_func", alu_func_code, v.fn);
    check("exec_rs1", alu_rs1, v.rs1);
    check("exec_rs2", alu_rs2, v.rs2);
    check("exec_imm", alu_imm, v.imm);
    check("exec_pc", alu_pc, v.pc);
    check("exec_busy", busy, 1);
    check("exec_no_resp", resp_valid, 2'b00);
    @(negedge clk);
    check("resp_valid", resp_valid, oh);
    check("resp_signal_nop", alu_signal, NOP);
    check("resp_result", resp_result, v.exp_res);
    check("resp_sign", resp_sign_bits, v.exp_sign);
    @(negedge clk);
    check("done_busy", busy, 0);
    check("done_resp_valid", resp_valid, 2'b00);
  endtask

  initial begin
    vec_t a, b;
    bit ok;
    int gc[$];
    logic [1:0] gv[$];

    vecs[0] = '{0, SIG_BIN, FN_ADD, 64'd5, 64'd7, 64'd0, 32'd0, 64'd12, POS};
    vecs[1] = '{1, SIG_BIN, FN_SUB, 64'd3, 64'd5, 64'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFE, NEG};
    vecs[2] = '{1, SIG_PC, FN_ADD, 64'd0, 64'd0, 64'h20, 32'h100, 64'h120, POS};
    vecs[3] = '{0, SIG_BIN, FN_SUB, 64'd10, 64'd10, 64'd0, 32'd0, 64'd0, ZERO};
    vecs[4] = '{0, SIG_BIN, FN_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 32'd0, 64'd0, ZERO};
    vecs[5] = '{1, SIG_BIN, FN_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 32'd0, 64'h8000_0000_0000_0000, NEG};
    vecs[6] = '{0, SIG_PC, 4'hA, 64'd0, 64'd0, 64'd8, 32'hFFFF_FFF0, 64'hFFFF_FFF8, POS};

    // reset values
    #3;
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_alu_signal", alu_signal, NOP);
    check("rst_alu_rs1", alu_rs1, 0);
    check("rst_alu_pc", alu_pc, 0);
    check("rst_resp_result", resp_result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_single(vecs[i]);

    // tie and alternation straight out of reset
    @(negedge clk);
    rst_n = 1'b0;
    a = '{0, SIG_BIN, FN_ADD, 64'd1, 64'd2, 64'd0, 32'd0, 64'd3, POS};
    b = '{1, SIG_BIN, FN_SUB, 64'd9, 64'd4, 64'd0, 32'd0, 64'd5, POS};
    drive_slot(a);
    drive_slot(b);
    req_valid = 2'b11;
    resp_ready = 2'b11;
    #1;
    check("tie_in_reset_ready", req_ready, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (req_ready != 2'b00) begin
        gc.push_back(cyc);
        gv.push_back(req_ready);
        if (req_ready == 2'b01) push_exp(0, POS, 64'd3);
        else push_exp(1, POS, 64'd5);
      end
      @(negedge clk);
      #1;
    end
    req_valid = 2'b00;
    check("tie_grant_count", gc.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gc.size()) begin
        check("tie_grant_cycle", gc[k], 3 * k);
        check("tie_grant_slot", gv[k], (k % 2 == 1) ? 2'b10 : 2'b01);
      end
    end
    repeat (3) @(negedge clk);

    // back-pressure with wrong-slot resp_ready
    drive_slot(vecs[2]);
    req_valid = 2'b10;
    resp_ready = 2'b00;
    #1;
    wait_ready(2'b10, ok);
    push_exp(1, POS, 64'h120);
    @(negedge clk);
    drive_slot(vecs[0]);
    req_valid = 2'b01;
    resp_ready = 2'b01;
    #1;
    check("bp_exec_ready", req_ready, 2'b00);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("bp_resp_valid", resp_valid, 2'b10);
      check("bp_resp_result", resp_result, 64'h120);
      check("bp_req_ready", req_ready, 2'b00);
      @(negedge clk);
    end
    req_valid = 2'b00;
    resp_ready = 2'b10;
    @(negedge clk);
    check("bp_done_busy", busy, 0);
    resp_ready = 2'b11;

    // reset during EXEC discards the operation
    drive_slot(vecs[0]);
    req_valid = 2'b01;
    #1;
    wait_ready(2'b01, ok);
    push_exp(0, POS, 64'd12);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 2'b00);
    check("mid_rst_resp_valid", resp_valid, 2'b00);
    check("mid_rst_signal", alu_signal, NOP);
    check("mid_rst_rs1", alu_rs1, 0);
    check("mid_rst_func", alu_func_code, 0);
    check("mid_rst_result", resp_result, 0);
    check("mid_rst_sign", resp_sign_bits, 0);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_no_resp", resp_valid, 2'b00);
    end
    run_single(vecs[1]);

    // withdrawn request while in RESP leaves last_grant alone
    run_single(vecs[0]);
    drive_slot(vecs[5]);
    req_valid = 2'b10;
    resp_ready = 2'b00;
    #1;
    wait_ready(2'b10, ok);
    push_exp(1, NEG, 64'h8000_0000_0000_0000);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    drive_slot(vecs[3]);
    req_valid = 2'b01;
    #1;
    check("wd_resp_ready", req_ready, 2'b00);
    @(negedge clk);
    req_valid = 2'b00;
    check("wd_resp_held", resp_valid, 2'b10);
    resp_ready = 2'b11;
    @(negedge clk);
    check("wd_idle", busy, 0);
    req_valid = 2'b11;
    #1;
    check("wd_tie_grant", req_ready, 2'b01);
    if (req_ready == 2'b01) push_exp(0, ZERO, 64'd0);
    else push_exp(1, NEG, 64'h8000_0000_0000_0000);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
